// File: rtl/cic_interp_if.sv
// Signal bundle for the CIC interpolator: enable, strobes and low-rate samples in,
// interpolated samples and status flags out.
interface cic_interp_if #(
  parameter int DATAIN_WIDTH  = 16,
  parameter int DATAOUT_WIDTH = DATAIN_WIDTH
);
  logic                     en_i;
  logic [DATAIN_WIDTH-1:0]  data_i;
  logic                     act_i;
  logic                     act_out_i;
  logic [DATAOUT_WIDTH-1:0] data_o;
  logic                     val_o;
  logic                     overrun_o;

  modport master (
    output en_i, data_i, act_i, act_out_i,
    input  data_o, val_o, overrun_o
  );

  modport slave (
    input  en_i, data_i, act_i, act_out_i,
    output data_o, val_o, overrun_o
  );
endinterface

// File: rtl/cic_interp.sv
// N-stage CIC interpolator: comb chain at the act_i rate, zero-stuffing upsampler,
// integrator chain at the act_out_i rate, all arithmetic wrapping modulo 2^W.
module cic_interp #(
  parameter int DATAIN_WIDTH  = 16,
  parameter int DATAOUT_WIDTH = DATAIN_WIDTH,
  parameter int M             = 2,
  parameter int N             = 5,
  parameter int MAXRATE       = 64,
  parameter int bitgrowth     = 29
) (
  input  logic         clk_i,
  input  logic         rst_i,
  cic_interp_if.slave  bus
);

  localparam int W = DATAIN_WIDTH + bitgrowth;

  logic [W-1:0] sampler;
  logic [W-1:0] delay [N][M];
  logic [W-1:0] pipe [N];
  logic [W-1:0] comb_in [N];
  logic [W-1:0] integ [N];
  logic [N:0]   cv;
  logic [N:0]   ov;
  logic         pending;
  logic         overrun;

  logic         strobe_in;
  logic         strobe_out;
  logic         produce;
  logic         consume;
  logic [W-1:0] data_ext;
  logic [W-1:0] stuffed;

  assign strobe_in  = bus.en_i & bus.act_i;
  assign strobe_out = bus.en_i & bus.act_out_i;
  assign produce    = strobe_in & cv[N-1];
  assign consume    = strobe_out & pending;
  assign data_ext   = W'(signed'(bus.data_i));
  assign stuffed    = consume ? pipe[N-1] : '0;

  always_comb begin
    comb_in[0] = sampler;
    for (int i = 1; i < N; i++) begin
      comb_in[i] = pipe[i-1];
    end
  end

  // Comb section: each stage subtracts its input from M strobes earlier.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sampler <= '0;
      cv      <= '0;
      for (int i = 0; i < N; i++) begin
        pipe[i] <= '0;
        for (int j = 0; j < M; j++) begin
          delay[i][j] <= '0;
        end
      end
    end else if (strobe_in) begin
      sampler <= data_ext;
      cv      <= {cv[N-1:0], 1'b1};
      for (int i = 0; i < N; i++) begin
        pipe[i]     <= comb_in[i] - delay[i][M-1];
        delay[i][0] <= comb_in[i];
        for (int j = 1; j < M; j++) begin
          delay[i][j] <= delay[i][j-1];
        end
      end
    end
  end

  // A fresh comb sample wins over a same-edge consume, so pending stays set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= produce & pending & ~consume;
      if (produce) begin
        pending <= 1'b1;
      end else if (consume) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ov <= '0;
      for (int i = 0; i < N; i++) begin
        integ[i] <= '0;
      end
    end else if (strobe_out) begin
      ov       <= {ov[N-1:0], ov[0] | consume};
      integ[0] <= integ[0] + stuffed;
      for (int i = 1; i < N; i++) begin
        integ[i] <= integ[i] + integ[i-1];
      end
    end
  end

  assign bus.data_o    = integ[N-1][W-1 -: DATAOUT_WIDTH];
  assign bus.val_o     = ov[N];
  assign bus.overrun_o = overrun;

endmodule

// File: doc/cic_interp.md
CIC_INTERP -- requirements
Module: cic_interp

Interface
REQ-001 Parameter DATAIN_WIDTH, default 16: input sample width, two's complement.
REQ-002 Parameter DATAOUT_WIDTH, default DATAIN_WIDTH: output sample width, at most DATAIN_WIDTH+bitgrowth.
REQ-003 Parameter M, default 2: differential delay of each comb stage.
REQ-004 Parameter N, default 5: number of comb stages and number of integrator stages.
REQ-005 Parameter MAXRATE, default 64: maximum interpolation ratio R.
REQ-006 Parameter bitgrowth, default 29: internal width growth; ceil(log2((M*MAXRATE)^N/MAXRATE)) for the defaults.
REQ-007 The design shall have one clock; reset is synchronous and active-high.
REQ-008 clk_i  in  1  sole clock; all registers update on its rising edge.
REQ-009 rst_i  in  1  synchronous, active-high reset.
REQ-010 en_i  in  1  global clock enable; when low, all state freezes and strobes are ignored.
REQ-011 data_i  in  DATAIN_WIDTH  low-rate input sample, sampled on act_i.
REQ-012 act_i  in  1  low-rate strobe, one cycle per input sample.
REQ-013 act_out_i  in  1  high-rate strobe, one cycle per output sample; nominally R strobes per act_i.
REQ-014 data_o  out  DATAOUT_WIDTH  interpolated output: the top DATAOUT_WIDTH bits of the last integrator.
REQ-015 val_o  out  1  sticky flag meaning the output pipeline is filled.
REQ-016 overrun_o  out  1  one-cycle pulse when a comb sample is lost.

Function
REQ-017 Internal width W=DATAIN_WIDTH+bitgrowth; data_i shall be sign-extended to W; all arithmetic is modulo 2^W (wrap, no saturation).
REQ-018 Comb chain, on each en_i&&act_i:
- sampler <= extended data_i.
- Stage 0: delay line of M registers fed by sampler; pipe[0] <= sampler - delay[0][M-1].
- Stage i (1..N-1): delay line fed by pipe[i-1]; pipe[i] <= pipe[i-1] - delay[i][M-1].
REQ-019 Comb valid shift register cv[0..N], on each en_i&&act_i: cv[0]<=1 and cv[i]<=cv[i-1].
- A strobe with cv[N-1]=1 (pre-edge) writes a valid sample into pipe[N-1] ("produce").
REQ-020 Pending flag set/clear:
- A produce sets pending at the same edge.
- en_i&&act_out_i with pending=1 ("consume") clears pending, unless a produce occurs at the same edge; in that case set wins.
REQ-021 Upsampler: stuffed value = pipe[N-1] (pre-edge) when consume, else zero.
REQ-022 Integrators, on each en_i&&act_out_i:
- integ[0] <= integ[0] + stuffed.
- integ[i] <= integ[i] + integ[i-1] (pre-edge values), for i=1..N-1.
REQ-023 data_o shall equal integ[N-1][W-1:W-DATAOUT_WIDTH], combinationally from the register.
REQ-024 Output valid shift register ov[0..N]:
- ov[0] set on the first consume; ov[i]<=ov[i-1] on each en_i&&act_out_i.
- val_o = ov[N], held at 1 until reset.
REQ-025 overrun_o shall pulse high for one cycle after a produce edge at which pending was 1 and no consume occurred; the older sample is overwritten.
REQ-026 Simultaneous act_i and act_out_i shall be legal; the comb and integrator sections update independently in the same cycle.
REQ-027 DC gain shall be (R*M)^N/R; with defaults and R=MAXRATE, steady-state data_o equals the DC input exactly.
REQ-028 act_i and act_out_i while en_i=0 shall have no effect, and shall not be remembered.

Reset
REQ-029 rst_i high at a clock edge shall clear to zero: sampler, all delay, pipe and integ registers, cv, ov, pending and overrun_o.
REQ-030 After reset, data_o=0, val_o=0 and overrun_o=0 from the next cycle, including when reset is asserted mid-stream.
REQ-031 rst_i shall have priority over en_i and both strobes.

Verification
REQ-032 Reset mid-stream:
- Stimulus: streaming defaults, rst_i high for 3 cycles.
- Response: data_o=0, val_o=0, overrun_o=0 from the first reset edge; after release, val_o stays 0 until N act_out_i strobes after the first consume.
REQ-033 DC gain:
- Stimulus: defaults, act_out_i every cycle, act_i every 64th cycle, data_i=1000.
- Response: val_o=1 after fill; data_o=1000 on every output once the transient settles (>= (N+1)*64 cycles).
REQ-034 Impulse / hold:
- Stimulus: N=1, M=1, bitgrowth=0, R=4, data_i=5 for one sample then 0.
- Response: data_o=5 for exactly 4 act_out_i strobes, then 0.
REQ-035 Overrun:
- Stimulus: act_i every cycle, act_out_i every 2nd cycle, after comb fill.
- Response: overrun_o pulses once per unconsumed produce; never pulses when act_out_i rate >= act_i rate.
REQ-036 Simultaneous and freeze:
- Stimulus 1: act_i and act_out_i in the same cycle with pending=1.
- Response 1: old sample consumed, pending remains 1, no overrun_o.
- Stimulus 2: en_i=0 for 10 cycles with strobes toggling.
- Response 2: data_o, val_o and all state unchanged.
